// File: rtl/coef_bank_mac.sv
// Four-bank coefficient RAM with a 40-sample delay line and a serial MAC.
// Define MAC_SAT_EN to saturate oMacOut; otherwise acc[30:15] wraps.
module coef_bank_mac #(
    parameter int unsigned TAPS_PER_BANK = 10,
    parameter int unsigned ACC_W         = 38
) (
    input  logic               iClk12M,
    input  logic               iRsn,
    input  logic               iEnSample600k,
    input  logic signed [15:0] iFirIn,
    input  logic               iCsnRam,
    input  logic               iWrnRam,
    input  logic        [1:0]  iModuleSel,
    input  logic        [3:0]  iAddrRam,
    input  logic signed [15:0] iWtDtRam,
    input  logic               iEnMAC,
    output logic signed [15:0] oRdDt,
    output logic               oRdValid,
    output logic signed [15:0] oMacOut,
    output logic               oMacValid
);

    localparam int unsigned NTaps = 4 * TAPS_PER_BANK;
    localparam int unsigned IdxW  = $clog2(NTaps);

    typedef enum logic [1:0] {StIdle, StAcc, StDump} state_e;

    state_e                    state_q, state_d;
    logic signed [15:0]        coef_q [NTaps];
    logic signed [15:0]        coef_d [NTaps];
    logic signed [15:0]        dline_q [NTaps];
    logic signed [15:0]        dline_d [NTaps];
    logic signed [15:0]        rd_dt_q, rd_dt_d;
    logic signed [15:0]        smp_q, smp_d;
    logic                      rd_valid_q, rd_valid_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        mac_out_q, mac_out_d;
    logic                      mac_valid_q, mac_valid_d;

    logic                      in_range;
    logic        [IdxW-1:0]    idx;
    logic signed [31:0]        prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [15:0]        scaled;

    assign in_range = 32'(iAddrRam) < TAPS_PER_BANK;
    assign idx      = IdxW'(32'(iModuleSel) * TAPS_PER_BANK + 32'(iAddrRam));
    assign prod     = rd_dt_q * smp_q;
    assign prod_ext = {{(ACC_W - 32){prod[31]}}, prod};

`ifdef MAC_SAT_EN
    // acc >>> 15 fits 16 bits only when all bits above bit 30 match the sign.
    always_comb begin
        if ((&acc_q[ACC_W-1:30]) || !(|acc_q[ACC_W-1:30])) begin
            scaled = acc_q[30:15];
        end else begin
            scaled = acc_q[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
        end
    end
`else
    assign scaled = acc_q[30:15];
`endif

    always_comb begin
        coef_d      = coef_q;
        dline_d     = dline_q;
        rd_dt_d     = rd_dt_q;
        smp_d       = smp_q;
        rd_valid_d  = 1'b0;
        acc_d       = acc_q;
        state_d     = state_q;
        mac_out_d   = mac_out_q;
        mac_valid_d = 1'b0;

        if (!iCsnRam) begin
            if (!iWrnRam) begin
                if (in_range) begin
                    coef_d[idx] = iWtDtRam;
                end
            end else begin
                rd_valid_d = 1'b1;
                // Reads sample dline_q, so a same-edge shift is not visible.
                if (in_range) begin
                    rd_dt_d = coef_q[idx];
                    smp_d   = dline_q[idx];
                end else begin
                    rd_dt_d = '0;
                    smp_d   = '0;
                end
            end
        end

        if (iEnSample600k) begin
            dline_d[0] = iFirIn;
            for (int k = 1; k < NTaps; k++) begin
                dline_d[k] = dline_q[k-1];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (iEnMAC) begin
                    state_d = StAcc;
                    acc_d   = prod_ext;
                end
            end
            StAcc: begin
                if (rd_valid_q) begin
                    acc_d = acc_q + prod_ext;
                end
                if (!iEnMAC) begin
                    state_d = StDump;
                end
            end
            StDump: begin
                mac_out_d   = scaled;
                mac_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q     <= StIdle;
            coef_q      <= '{default: '0};
            dline_q     <= '{default: '0};
            rd_dt_q     <= '0;
            smp_q       <= '0;
            rd_valid_q  <= 1'b0;
            acc_q       <= '0;
            mac_out_q   <= '0;
            mac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            coef_q      <= coef_d;
            dline_q     <= dline_d;
            rd_dt_q     <= rd_dt_d;
            smp_q       <= smp_d;
            rd_valid_q  <= rd_valid_d;
            acc_q       <= acc_d;
            mac_out_q   <= mac_out_d;
            mac_valid_q <= mac_valid_d;
        end
    end

    assign oRdDt     = rd_dt_q;
    assign oRdValid  = rd_valid_q;
    assign oMacOut   = mac_out_q;
    assign oMacValid = mac_valid_q;

endmodule
